// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcodes, funct3 values,
// FSM encoding and the funct3/funct7 -> ALU opcode decoder.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Only funct7[5] distinguishes ADD/SUB and SRL/SRA; it is ignored elsewhere.
    function automatic logic [3:0] decode_op(input logic [2:0] func3, input logic [6:0] func7);
        logic [3:0] op;
        op = ALU_ADD;
        case (func3)
            F3_ADD_SUB: op = func7[5] ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = func7[5] ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two request channels, the ALU side and the response channel.
// Handshake rule for every channel: a transfer happens in a cycle where valid
// and ready are both high; the sender keeps payload stable while valid is high
// and ready is low, and ready may depend combinationally on the receiver state.
interface alu_share_arbiter_if #(
    parameter int DW   = 32,
    parameter int TAGW = 4
);
    logic            r0_valid_i;
    logic            r0_ready_o;
    logic [2:0]      r0_func3_i;
    logic [6:0]      r0_func7_i;
    logic [DW-1:0]   r0_opa_i;
    logic [DW-1:0]   r0_opb_i;
    logic [TAGW-1:0] r0_tag_i;

    logic            r1_valid_i;
    logic            r1_ready_o;
    logic [2:0]      r1_func3_i;
    logic [6:0]      r1_func7_i;
    logic [DW-1:0]   r1_opa_i;
    logic [DW-1:0]   r1_opb_i;
    logic [TAGW-1:0] r1_tag_i;

    logic            alu_en_o;
    logic [3:0]      alu_op_o;
    logic [DW-1:0]   alu_a_o;
    logic [DW-1:0]   alu_b_o;
    logic [DW-1:0]   alu_res_i;

    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic            rsp_id_o;
    logic [TAGW-1:0] rsp_tag_o;
    logic [DW-1:0]   rsp_data_o;

    logic            busy_o;

    modport slave (
        input  r0_valid_i, r0_func3_i, r0_func7_i, r0_opa_i, r0_opb_i, r0_tag_i,
        input  r1_valid_i, r1_func3_i, r1_func7_i, r1_opa_i, r1_opb_i, r1_tag_i,
        output r0_ready_o, r1_ready_o,
        output alu_en_o, alu_op_o, alu_a_o, alu_b_o,
        input  alu_res_i,
        output rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_data_o,
        input  rsp_ready_i,
        output busy_o
    );

    modport master (
        output r0_valid_i, r0_func3_i, r0_func7_i, r0_opa_i, r0_opb_i, r0_tag_i,
        output r1_valid_i, r1_func3_i, r1_func7_i, r1_opa_i, r1_opb_i, r1_tag_i,
        input  r0_ready_o, r1_ready_o,
        input  alu_en_o, alu_op_o, alu_a_o, alu_b_o,
        output alu_res_i,
        input  rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_data_o,
        output rsp_ready_i,
        input  busy_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a single valid requester always wins, a tie
// goes to the requester named by rr_q. No grant when en is low.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       en,
    input  logic       rr_q,
    output logic [1:0] grant
);

    // One-hot grant selection
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) grant = rr_q ? 2'b10 : 2'b01;
            else                grant = valid;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters. Accept ->
// EXEC (ALU driven for one cycle) -> RESP (result held until taken). A new
// request can be accepted in the same cycle the previous result is taken.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DW   = 32,
    parameter int TAGW = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    alu_share_arbiter_if.slave    bus,
    output state_t                dbg_state_o
);

    state_t          state_q, state_d;
    logic            rr_q;
    logic [3:0]      op_q;
    logic [DW-1:0]   a_q, b_q, data_q;
    logic [TAGW-1:0] tag_q;
    logic            id_q;

    logic            accept_win;
    logic [1:0]      grant;
    logic            accept;

    // Accept while idle, or while handing the current result over
    assign accept_win = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready_i);

    rr_arb2 u_arb (
        .valid (({bus.r1_valid_i, bus.r0_valid_i})),
        .en    (accept_win),
        .rr_q  (rr_q),
        .grant (grant)
    );

    assign accept         = |grant;
    assign bus.r0_ready_o = grant[0];
    assign bus.r1_ready_o = grant[1];

    assign bus.alu_en_o    = (state_q == ST_EXEC);
    assign bus.alu_op_o    = op_q;
    assign bus.alu_a_o     = a_q;
    assign bus.alu_b_o     = b_q;
    assign bus.rsp_valid_o = (state_q == ST_RESP);
    assign bus.rsp_id_o    = id_q;
    assign bus.rsp_tag_o   = tag_q;
    assign bus.rsp_data_o  = data_q;
    assign bus.busy_o      = (state_q != ST_IDLE);
    assign dbg_state_o     = state_q;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready_i) state_d = accept ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the granted request and move round-robin priority to the other side
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q  <= 1'b0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            tag_q <= '0;
            id_q  <= 1'b0;
        end else if (accept) begin
            rr_q  <= grant[0];
            id_q  <= grant[1];
            if (grant[1]) begin
                op_q  <= decode_op(bus.r1_func3_i, bus.r1_func7_i);
                a_q   <= bus.r1_opa_i;
                b_q   <= bus.r1_opb_i;
                tag_q <= bus.r1_tag_i;
            end else begin
                op_q  <= decode_op(bus.r0_func3_i, bus.r0_func7_i);
                a_q   <= bus.r0_opa_i;
                b_q   <= bus.r0_opb_i;
                tag_q <= bus.r0_tag_i;
            end
        end
    end

    // Register the ALU result at the end of the execute cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                 data_q <= '0;
        else if (state_q == ST_EXEC) data_q <= bus.alu_res_i;
    end

endmodule
